// File: rtl/nibble_uart_pkg.sv
// Shared types and constants for the nibble-fed UART transmitter.
package nibble_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } ser_state_e;

  // Bit positions inside the status nibble returned to the CPU.
  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_BUSY   = 2;
  localparam int unsigned ST_HIPEND = 3;

  // 8N1: one start bit, eight data bits, one stop bit.
  localparam int unsigned BITS_PER_FRAME = 10;
  localparam int unsigned DATA_BITS      = BITS_PER_FRAME - 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; accepts a push when full if a
// pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // Decode full/empty and which requests actually take effect.
  always_comb begin
    full    = (count_q == DepthCnt);
    empty   = (count_q == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rdata   = mem_q[rd_ptr_q];
    count   = count_q;
  end

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nibble_uart_tx.sv
// Pairs CPU output nibbles into bytes, queues them and sends 8N1 UART frames.
module nibble_uart_tx
  import nibble_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] out_nibble,
  input  logic       out_wr,
  output logic [3:0] status,
  output logic       tx,
  output logic       overflow
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [2:0]       BitLast  = 3'(DATA_BITS - 1);

  logic            hi_pending_q;
  logic [3:0]      hi_q;
  logic            push, pop;
  logic [7:0]      push_data, head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            overflow_q;
  logic [3:0]      status_q;

  ser_state_e      state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            baud_end;

  // Second nibble of a pair completes the byte; pop whenever a frame may begin.
  always_comb begin
    push      = out_wr && hi_pending_q;
    push_data = {hi_q, out_nibble};
    baud_end  = (baud_q == BaudLast);
    pop       = !fifo_empty &&
                ((state_q == StIdle) || ((state_q == StStop) && baud_end));
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Nibble assembler and sticky overflow on a rejected push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_pending_q <= 1'b0;
      hi_q         <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (out_wr) begin
        if (!hi_pending_q) hi_q <= out_nibble;
        hi_pending_q <= !hi_pending_q;
      end
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Status nibble lags the state it reports by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q <= 4'b0010;
    end else begin
      status_q[ST_FULL]   <= (fifo_count == DepthCnt);
      status_q[ST_EMPTY]  <= (fifo_count == '0);
      status_q[ST_BUSY]   <= (state_q != StIdle);
      status_q[ST_HIPEND] <= hi_pending_q;
    end
  end

  // Serializer FSM; tx is registered alongside the state so it cannot glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= head;
            state_q <= StStart;
            tx_q    <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == BitLast) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              // Next byte already waiting: start bit follows stop bit directly.
              shift_q <= head;
              state_q <= StStart;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign status   = status_q;
  assign tx       = tx_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Bench for nibble_uart_tx: frame-level reference model, UART receiver and
// directed scenarios with literal expectations.
module tb_nibble_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] out_nibble = '0;
  logic       out_wr = 1'b0;
  logic [3:0] status;
  logic       tx;
  logic       overflow;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  nibble_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .out_nibble (out_nibble),
    .out_wr     (out_wr),
    .status     (status),
    .tx         (tx),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (byte queue + frame position) ----------
  logic [7:0] m_q[$];
  bit         m_hi_pend = 0;
  logic [3:0] m_hi = '0;
  bit         m_ovf = 0;
  int         m_pos = -1;  // cycle within current frame, -1 when idle
  logic [7:0] m_cur = '0;
  logic [3:0] m_status = 4'b0010;
  bit         m_tx = 1;

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_hi_pend = 0;
      m_hi = '0;
      m_ovf = 0;
      m_pos = -1;
      m_status = 4'b0010;
      m_tx = 1;
    end else begin
      int  sz;
      bit  popped;
      sz = m_q.size();
      m_status = {m_hi_pend, m_pos >= 0, sz == 0, sz == DEPTH};
      popped = 0;
      if (m_pos < 0 || m_pos == FRAME - 1) begin
        if (sz > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
          popped = 1;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      if (out_wr) begin
        if (m_hi_pend) begin
          if (sz < DEPTH || popped) m_q.push_back({m_hi, out_nibble});
          else m_ovf = 1;
          m_hi_pend = 0;
        end else begin
          m_hi = out_nibble;
          m_hi_pend = 1;
        end
      end
      m_tx = (m_pos < 0) ? 1'b1 : frame_bit(m_cur, m_pos / CLK_DIV);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("tx", 64'(tx), 64'(m_tx));
      check("status", 64'(status), 64'(m_status));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  // ---------------- UART receiver on the DUT line ---------------------------
  logic [7:0] rx_q[$];
  bit         rx_act = 0;
  int         rx_pos = 0;
  logic [7:0] rx_sh = '0;

  always @(negedge clock) begin
    if (!reset) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1;
        rx_pos = 0;
      end
    end else begin
      rx_pos++;
      if (rx_pos % CLK_DIV == CLK_DIV / 2) begin
        if (rx_pos / CLK_DIV == 0) check("rx_start", 64'(tx), 64'(0));
        else if (rx_pos / CLK_DIV <= 8) rx_sh[rx_pos / CLK_DIV - 1] = tx;
        else begin
          check("rx_stop", 64'(tx), 64'(1));
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
  end

  // Length of the most recent contiguous busy stretch seen on status.
  int busy_run = 0;
  int last_run = 0;
  always @(negedge clock) begin
    if (!reset) busy_run = 0;
    else if (status[2]) busy_run++;
    else if (busy_run > 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic wr_nib(input logic [3:0] n);
    out_nibble = n;
    out_wr = 1'b1;
    @(posedge clock);
    #1;
    out_wr = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_nib(b[7:4]);
    wr_nib(b[3:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_tx_low(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx == 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(name, 64'(1), 64'(0));
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp);
    if (rx_q.size() == 0) check(name, 64'hdead, 64'(exp));
    else check(name, 64'(rx_q.pop_front()), 64'(exp));
  endtask

  // ---------------- directed scenarios -------------------------------------
  initial begin
    bit ok;
    bit pat[10];
    logic [39:0] got, expw;
    logic [7:0] burst[6];

    // Reset then idle.
    #1 reset = 1'b0;
    chk_en = 1;
    idle(3);
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_status", 64'(status), 64'(4'b0010));
    check("reset_ovf", 64'(overflow), 64'(0));
    reset = 1'b1;
    idle(100);
    check("idle_tx", 64'(tx), 64'(1));
    check("idle_status", 64'(status), 64'(4'b0010));

    // Single byte 0x41: literal line pattern.
    pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 40; i++) expw[i] = pat[i / CLK_DIV];
    wr_nib(4'h4);
    wr_nib(4'h1);
    wait_tx_low("single_start_timeout", ok);
    if (ok) begin
      got[0] = tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clock);
        got[i] = tx;
        if (i == 20) check("single_busy_mid", 64'(status[2]), 64'(1));
      end
      check("single_wave", 64'(got), 64'(expw));
    end
    idle(10);
    check("single_busy_after", 64'(status[2]), 64'(0));
    check("single_len", 64'(last_run), 64'(40));
    check_rx("single_rx", 8'h41);

    // Half byte then completion.
    wr_nib(4'hA);
    idle(3);
    check("half_status", 64'(status), 64'(4'b1010));
    check("half_tx", 64'(tx), 64'(1));
    wr_nib(4'h5);
    idle(50);
    check_rx("half_rx", 8'hA5);

    // Back-to-back frames.
    wr_byte(8'h55);
    wr_byte(8'hAA);
    wr_byte(8'h0F);
    idle(140);
    check("b2b_len", 64'(last_run), 64'(120));
    check_rx("b2b_rx0", 8'h55);
    check_rx("b2b_rx1", 8'hAA);
    check_rx("b2b_rx2", 8'h0F);

    // Overflow: one byte in flight, six more written behind it.
    burst = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    wr_byte(8'h11);
    for (int i = 0; i < 6; i++) wr_byte(burst[i]);
    idle(1);
    check("ovf_full", 64'(status[0]), 64'(1));
    check("ovf_flag", 64'(overflow), 64'(1));
    idle(5 * FRAME + 20);
    check_rx("ovf_rx0", 8'h11);
    for (int i = 0; i < 4; i++) check_rx("ovf_rx", burst[i]);
    check("ovf_rx_count", 64'(rx_q.size()), 64'(0));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset during data bit 3 of a frame.
    wr_byte(8'h3C);
    wait_tx_low("rst_start_timeout", ok);
    repeat (4 * CLK_DIV + 2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_async_tx", 64'(tx), 64'(1));
    check("rst_async_status", 64'(status), 64'(4'b0010));
    check("rst_async_ovf", 64'(overflow), 64'(0));
    idle(3);
    reset = 1'b1;
    idle(100);
    check("rst_no_frame", 64'(rx_q.size()), 64'(0));
    check("rst_tx_idle", 64'(tx), 64'(1));
    check("rst_status_idle", 64'(status), 64'(4'b0010));

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nibble_uart_tx.md
Name: nibble_uart_tx

Overview:
- Peripheral on the far side of the Nibbler CPU's 4-bit I/O port.
- Consumes nibbles written by the CPU's OUT instruction (output-port latch plus its write strobe) and assembles nibble pairs into bytes.
- Buffers bytes in a small FIFO and serializes them as 8N1 UART frames.
- Returns a 4-bit status nibble that the CPU reads through its input-port bus driver (IN instruction), so software can poll before writing.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range 2..4095.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2, minimum 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- out_nibble  input  4  CPU output-port value.
- out_wr  input  1  one-cycle strobe; out_nibble is valid in that cycle (CPU OUT write).
- status  output  4  to CPU input port: [0] fifo_full, [1] fifo_empty, [2] tx_busy, [3] hi_pending.
- tx  output  1  UART serial line; idles high.
- overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset (reset=0, asynchronous) and the values held while low:
  - tx=1, overflow=0, FIFO empty, hi_pending=0, state IDLE, bit counters 0.
  - status=4'b0010.
  - Any frame in progress is aborted immediately; tx returns high with no glitch to 0.
- Assembler, one cycle per out_wr:
  - out_wr with hi_pending=0: latch out_nibble as high nibble; hi_pending becomes 1.
  - out_wr with hi_pending=1: form byte {hi, out_nibble}, request a FIFO push, clear hi_pending.
  - out_wr held high N cycles counts as N writes.
- FIFO push rules:
  - Accepted if count < FIFO_DEPTH, or if count == FIFO_DEPTH and the serializer pops in the same cycle.
  - Otherwise the byte is dropped and overflow sets. overflow stays 1 until reset.
- Status timing:
  - status is registered; it reflects FIFO and hi_pending state one cycle after the causing edge.
  - fifo_full means count == FIFO_DEPTH. fifo_empty means count == 0. tx_busy means state != IDLE.
- Serializer FSM:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head byte into the shift register and go to START on the same edge. The first start-bit cycle on tx is the cycle after the byte becomes visible in the FIFO.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, LSB first, 8 bits; bit index 0..7, then go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*CLK_DIV cycles.
- Baud counter counts 0..CLK_DIV-1, resets at each bit boundary, and wraps with no drift.
- tx is driven from a register, so there are no combinational glitches.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package nibble_uart_pkg:
  - serializer state enum {IDLE, START, DATA, STOP}.
  - Status bit index constants ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_HIPEND=3.
  - Frame constant BITS_PER_FRAME=10.
- Sub-module sync_fifo, parameterised on WIDTH and DEPTH, with push/pop/full/empty/count.
- The assembler and serializer FSM stay in nibble_uart_tx.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset then idle:
  - Stimulus: hold reset=0 for 3 cycles, release.
  - Response: tx=1, status=4'b0010, overflow=0 for 100 cycles.
- Single byte:
  - Stimulus: out_wr with 0x4, then out_wr with 0x1.
  - Response: tx sequence 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles (40 cycles total); status[2]=1 during the frame, 0 after.
- Half byte:
  - Stimulus: out_wr with 0xA only.
  - Response: status[3]=1, no FIFO push, tx stays 1.
  - Stimulus: then out_wr with 0x5.
  - Response: frame carries 0xA5.
- Back-to-back:
  - Stimulus: write bytes 0x55, 0xAA, 0x0F.
  - Response: three contiguous frames with no idle cycle between stop and next start; exactly 120 cycles.
- Overflow:
  - Stimulus: while the first frame transmits, write 6 bytes.
  - Response: FIFO fills, status[0]=1. Bytes beyond capacity are dropped and overflow=1. Transmitted bytes match the first 5 written, in order.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3.
  - Response: tx=1 immediately (asynchronous), FIFO empty, overflow=0. After release no residual frame is sent.
